// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_pkg
// Description : Register address map of the accumulator register file.
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

  localparam logic [3:0] c_REG_R0   = 4'h0;
  localparam logic [3:0] c_REG_R1   = 4'h1;
  localparam logic [3:0] c_REG_R2   = 4'h2;
  localparam logic [3:0] c_REG_R3   = 4'h3;
  localparam logic [3:0] c_REG_R4   = 4'h4;
  localparam logic [3:0] c_REG_R5   = 4'h5;
  localparam logic [3:0] c_REG_R6   = 4'h6;
  localparam logic [3:0] c_REG_R7   = 4'h7;
  localparam logic [3:0] c_REG_DMAR = 4'h8;
  localparam logic [3:0] c_REG_IOFF = 4'h9;

endpackage
`default_nettype wire

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : States, opcodes and select encodings of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;
  import register_file_pkg::*;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } seq_state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_GET  = 4'h1,
    OP_PUT  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_LDI  = 4'h8,
    OP_LD   = 4'h9,
    OP_ST   = 4'hA,
    OP_HALT = 4'hF
  } opcode_e;

  localparam logic [2:0] c_ALU_ADD = 3'd0;
  localparam logic [2:0] c_ALU_SUB = 3'd1;
  localparam logic [2:0] c_ALU_AND = 3'd2;
  localparam logic [2:0] c_ALU_OR  = 3'd3;
  localparam logic [2:0] c_ALU_XOR = 3'd4;

  localparam logic [1:0] c_ACC_SRC_ALU  = 2'd0;
  localparam logic [1:0] c_ACC_SRC_DMEM = 2'd1;
  localparam logic [1:0] c_ACC_SRC_IMM  = 2'd2;

  localparam logic [1:0] c_FC_NONE        = 2'd0;
  localparam logic [1:0] c_FC_ILLEGAL_OP  = 2'd1;
  localparam logic [1:0] c_FC_BAD_REG     = 2'd2;
  localparam logic [1:0] c_FC_MEM_TIMEOUT = 2'd3;

  function automatic logic is_reg_addr(input logic [3:0] r);
    return r inside {c_REG_R0, c_REG_R1, c_REG_R2, c_REG_R3, c_REG_R4,
                     c_REG_R5, c_REG_R6, c_REG_R7, c_REG_DMAR, c_REG_IOFF};
  endfunction

  // GET, PUT and the five ALU ops all carry a register operand.
  function automatic logic is_reg_op(input logic [3:0] op);
    return (op >= OP_GET) && (op <= OP_XOR);
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    logic [2:0] sel;
    sel = c_ALU_ADD;
    case (op)
      OP_SUB:  sel = c_ALU_SUB;
      OP_AND:  sel = c_ALU_AND;
      OP_OR:   sel = c_ALU_OR;
      OP_XOR:  sel = c_ALU_XOR;
      default: sel = c_ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/req_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : req_timeout_counter
// Description : Counts cycles of an outstanding req; flags expiry at MEM_TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module req_timeout_counter #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ack,
  output logic expired
);

  localparam int c_CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic               r_active;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] w_count;
  logic               w_live;

  // The first req cycle counts as cycle 0 regardless of any stale count.
  assign w_count = start ? '0 : r_count;
  assign w_live  = start | r_active;
  assign expired = w_live & ~ack & (w_count == c_CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || ack || expired) begin
      r_active <= 1'b0;
      r_count  <= '0;
    end else if (w_live) begin
      r_active <= 1'b1;
      r_count  <= w_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sequencer
// Description : Fetch/decode/execute control FSM for the 8-bit accumulator datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int MEM_TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  output logic                      imem_req,
  input  logic                      imem_ack,
  input  logic [DATA_W-1:0]         imem_rdata,
  output logic                      dmem_req,
  output logic                      dmem_we,
  input  logic                      dmem_ack,
  output logic                      acc_write_enable,
  output logic [1:0]                acc_src,
  output logic                      read_get_to_acc,
  output logic                      write_put_acc,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic                      read_data_output_enable,
  output logic                      status_write_enable,
  output logic [2:0]                alu_op,
  output logic                      pc_advance,
  output logic                      halted,
  output logic                      fault,
  output logic [1:0]                fault_code
);

  seq_state_e  r_state;
  seq_state_e  w_state_nxt;
  seq_state_e  w_after_instr;
  logic [DATA_W-1:0] r_ir;
  logic [1:0]  r_fault_code;
  logic        w_fault_set;
  logic [1:0]  w_fault_code_nxt;
  logic [3:0]  w_op;
  logic [3:0]  w_operand;
  logic        w_req;
  logic        w_ack_live;
  logic        r_req_pending;
  logic        w_start;
  logic        w_expired;

  assign w_op       = r_ir[7:4];
  assign w_operand  = r_ir[3:0];
  assign fault_code = r_fault_code;

  // Acks only count while the matching request is actually raised.
  assign w_req      = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_ack_live = ((r_state == ST_FETCH) && imem_ack) ||
                      ((r_state == ST_MEM)   && dmem_ack);
  assign w_start    = w_req & ~r_req_pending;

  req_timeout_counter #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_req_timeout (
    .clk     (clk),
    .reset   (reset),
    .start   (w_start),
    .ack     (w_ack_live),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ir          <= '0;
      r_fault_code  <= c_FC_NONE;
      r_req_pending <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_req_pending <= w_req & ~w_ack_live & ~w_expired;
      if ((r_state == ST_FETCH) && imem_ack) begin
        r_ir <= imem_rdata;
      end
      if (w_fault_set) begin
        r_fault_code <= w_fault_code_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt             = r_state;
    w_fault_set             = 1'b0;
    w_fault_code_nxt        = c_FC_NONE;
    w_after_instr           = run ? ST_FETCH : ST_IDLE;
    imem_req                = 1'b0;
    dmem_req                = 1'b0;
    dmem_we                 = 1'b0;
    acc_write_enable        = 1'b0;
    acc_src                 = c_ACC_SRC_ALU;
    read_get_to_acc         = 1'b0;
    write_put_acc           = 1'b0;
    reg_addr                = '0;
    read_data_output_enable = 1'b0;
    status_write_enable     = 1'b0;
    alu_op                  = c_ALU_ADD;
    pc_advance              = 1'b0;
    halted                  = 1'b0;
    fault                   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_state_nxt = ST_FETCH;
        end
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_state_nxt = ST_DECODE;
        end else if (w_expired) begin
          w_state_nxt      = ST_FAULT;
          w_fault_set      = 1'b1;
          w_fault_code_nxt = c_FC_MEM_TIMEOUT;
        end
      end

      ST_DECODE: begin
        if (is_reg_op(w_op)) begin
          reg_addr = REG_ADDR_WIDTH'(w_operand);
        end
        case (w_op)
          OP_NOP, OP_LDI, OP_LD, OP_ST: w_state_nxt = ST_EXEC;
          OP_GET, OP_PUT, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            if (is_reg_addr(w_operand)) begin
              w_state_nxt = ST_EXEC;
            end else begin
              w_state_nxt      = ST_FAULT;
              w_fault_set      = 1'b1;
              w_fault_code_nxt = c_FC_BAD_REG;
            end
          end
          OP_HALT: w_state_nxt = ST_HALT;
          default: begin
            w_state_nxt      = ST_FAULT;
            w_fault_set      = 1'b1;
            w_fault_code_nxt = c_FC_ILLEGAL_OP;
          end
        endcase
      end

      ST_EXEC: begin
        if (is_reg_op(w_op)) begin
          reg_addr = REG_ADDR_WIDTH'(w_operand);
        end
        case (w_op)
          OP_NOP: begin
            pc_advance  = 1'b1;
            w_state_nxt = w_after_instr;
          end
          OP_GET: begin
            read_get_to_acc = 1'b1;
            pc_advance      = 1'b1;
            w_state_nxt     = w_after_instr;
          end
          OP_PUT: begin
            write_put_acc = 1'b1;
            pc_advance    = 1'b1;
            w_state_nxt   = w_after_instr;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            read_data_output_enable = 1'b1;
            acc_write_enable        = 1'b1;
            acc_src                 = c_ACC_SRC_ALU;
            status_write_enable     = 1'b1;
            alu_op                  = alu_op_of(w_op);
            pc_advance              = 1'b1;
            w_state_nxt             = w_after_instr;
          end
          OP_LDI: begin
            acc_write_enable = 1'b1;
            acc_src          = c_ACC_SRC_IMM;
            pc_advance       = 1'b1;
            w_state_nxt      = w_after_instr;
          end
          OP_LD, OP_ST: w_state_nxt = ST_MEM;
          default: begin
            w_state_nxt      = ST_FAULT;
            w_fault_set      = 1'b1;
            w_fault_code_nxt = c_FC_ILLEGAL_OP;
          end
        endcase
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_op == OP_ST);
        if (dmem_ack) begin
          if (w_op == OP_LD) begin
            acc_write_enable = 1'b1;
            acc_src          = c_ACC_SRC_DMEM;
          end
          pc_advance  = 1'b1;
          w_state_nxt = w_after_instr;
        end else if (w_expired) begin
          w_state_nxt      = ST_FAULT;
          w_fault_set      = 1'b1;
          w_fault_code_nxt = c_FC_MEM_TIMEOUT;
        end
      end

      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sequencer
// Description : Directed self-checking bench for reg_file_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sequencer;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       acc_write_enable;
    logic [1:0] acc_src;
    logic       read_get_to_acc;
    logic       write_put_acc;
    logic [3:0] reg_addr;
    logic       read_data_output_enable;
    logic       status_write_enable;
    logic [2:0] alu_op;
    logic       pc_advance;
    logic       halted;
    logic       fault;
    logic [1:0] fault_code;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       dmem_ack = 1'b0;
  logic       imem_req, dmem_req, dmem_we, acc_write_enable;
  logic [1:0] acc_src;
  logic       read_get_to_acc, write_put_acc;
  logic [3:0] reg_addr;
  logic       read_data_output_enable, status_write_enable;
  logic [2:0] alu_op;
  logic       pc_advance, halted, fault;
  logic [1:0] fault_code;
  outs_t      obs;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  reg_file_sequencer #(
    .DATA_W         (8),
    .REG_ADDR_WIDTH (4),
    .MEM_TIMEOUT    (16)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .run                     (run),
    .imem_req                (imem_req),
    .imem_ack                (imem_ack),
    .imem_rdata              (imem_rdata),
    .dmem_req                (dmem_req),
    .dmem_we                 (dmem_we),
    .dmem_ack                (dmem_ack),
    .acc_write_enable        (acc_write_enable),
    .acc_src                 (acc_src),
    .read_get_to_acc         (read_get_to_acc),
    .write_put_acc           (write_put_acc),
    .reg_addr                (reg_addr),
    .read_data_output_enable (read_data_output_enable),
    .status_write_enable     (status_write_enable),
    .alu_op                  (alu_op),
    .pc_advance              (pc_advance),
    .halted                  (halted),
    .fault                   (fault),
    .fault_code              (fault_code)
  );

  assign obs = {imem_req, dmem_req, dmem_we, acc_write_enable, acc_src,
                read_get_to_acc, write_put_acc, reg_addr,
                read_data_output_enable, status_write_enable, alu_op,
                pc_advance, halted, fault, fault_code};

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in IDLE with all handshake inputs low and run low.
  task automatic do_reset();
    reset    = 1'b1;
    run      = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    outs_t e;
    reset = 1'b1;
    run   = 1'b1;
    cyc();
    cyc();
    #1;
    e = '0;
    if (obs !== e) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", obs, e);
    end
    total++;
    reset = 1'b0;
    run   = 1'b0;
  endtask

  task automatic test_ldi_latency();
    outs_t e;
    do_reset();
    run = 1'b1;
    cyc();
    imem_ack = 1'b1; imem_rdata = 8'h85;
    #1;
    e = '0; e.imem_req = 1'b1;
    if (obs !== e) begin bad++; $display("FAIL ldi_fetch: got %h want %h", obs, e); end
    total++;
    cyc();
    imem_ack = 1'b0;
    #1;
    e = '0;
    if (obs !== e) begin bad++; $display("FAIL ldi_decode: got %h want %h", obs, e); end
    total++;
    cyc();
    #1;
    e = '0; e.acc_write_enable = 1'b1; e.acc_src = 2'd2; e.pc_advance = 1'b1;
    if (obs !== e) begin bad++; $display("FAIL ldi_exec: got %h want %h", obs, e); end
    total++;
    cyc();
    #1;
    e = '0; e.imem_req = 1'b1;
    if (obs !== e) begin bad++; $display("FAIL ldi_next_fetch: got %h want %h", obs, e); end
    total++;
  endtask

  task automatic test_program();
    logic [7:0] prog [7];
    outs_t      dec_e [7];
    outs_t      exe_e [7];
    outs_t      e;
    prog = '{8'h82, 8'h20, 8'h30, 8'h43, 8'h15, 8'h00, 8'h79};
    for (int k = 0; k < 7; k++) begin
      dec_e[k] = '0;
      exe_e[k] = '0;
      exe_e[k].pc_advance = 1'b1;
    end
    exe_e[0].acc_write_enable = 1'b1; exe_e[0].acc_src = 2'd2;
    exe_e[1].write_put_acc = 1'b1;
    exe_e[2].read_data_output_enable = 1'b1; exe_e[2].acc_write_enable = 1'b1;
    exe_e[2].status_write_enable = 1'b1;
    dec_e[3].reg_addr = 4'd3;
    exe_e[3].read_data_output_enable = 1'b1; exe_e[3].acc_write_enable = 1'b1;
    exe_e[3].status_write_enable = 1'b1; exe_e[3].alu_op = 3'd1; exe_e[3].reg_addr = 4'd3;
    dec_e[4].reg_addr = 4'd5;
    exe_e[4].read_get_to_acc = 1'b1; exe_e[4].reg_addr = 4'd5;
    dec_e[6].reg_addr = 4'd9;
    exe_e[6].read_data_output_enable = 1'b1; exe_e[6].acc_write_enable = 1'b1;
    exe_e[6].status_write_enable = 1'b1; exe_e[6].alu_op = 3'd4; exe_e[6].reg_addr = 4'd9;

    do_reset();
    run = 1'b1;
    cyc();
    for (int k = 0; k < 7; k++) begin
      imem_ack = 1'b1; imem_rdata = prog[k];
      #1;
      e = '0; e.imem_req = 1'b1;
      if (obs !== e) begin bad++; $display("FAIL prog_fetch[%0d]: got %h want %h", k, obs, e); end
      total++;
      cyc();
      imem_ack = 1'b0;
      #1;
      if (obs !== dec_e[k]) begin
        bad++; $display("FAIL prog_decode[%0d]: got %h want %h", k, obs, dec_e[k]);
      end
      total++;
      cyc();
      #1;
      if (obs !== exe_e[k]) begin
        bad++; $display("FAIL prog_exec[%0d]: got %h want %h", k, obs, exe_e[k]);
      end
      total++;
      cyc();
    end
  endtask

  task automatic test_mem();
    outs_t e;
    do_reset();
    run = 1'b1;
    cyc();
    imem_ack = 1'b1; imem_rdata = 8'h90;
    cyc();
    imem_ack = 1'b0;
    cyc();
    #1;
    e = '0;
    if (obs !== e) begin bad++; $display("FAIL ld_exec: got %h want %h", obs, e); end
    total++;
    cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      e = '0; e.dmem_req = 1'b1;
      if (obs !== e) begin bad++; $display("FAIL ld_wait[%0d]: got %h want %h", k, obs, e); end
      total++;
      cyc();
    end
    dmem_ack = 1'b1;
    #1;
    e = '0; e.dmem_req = 1'b1; e.acc_write_enable = 1'b1; e.acc_src = 2'd1; e.pc_advance = 1'b1;
    if (obs !== e) begin bad++; $display("FAIL ld_ack: got %h want %h", obs, e); end
    total++;
    cyc();
    dmem_ack = 1'b0;
    imem_ack = 1'b1; imem_rdata = 8'hA0;
    #1;
    e = '0; e.imem_req = 1'b1;
    if (obs !== e) begin bad++; $display("FAIL ld_next_fetch: got %h want %h", obs, e); end
    total++;
    cyc();
    imem_ack = 1'b0;
    cyc();
    dmem_ack = 1'b1;
    #1;
    e = '0;
    if (obs !== e) begin bad++; $display("FAIL st_exec_stray_ack: got %h want %h", obs, e); end
    total++;
    cyc();
    dmem_ack = 1'b0;
    #1;
    e = '0; e.dmem_req = 1'b1; e.dmem_we = 1'b1;
    if (obs !== e) begin bad++; $display("FAIL st_wait: got %h want %h", obs, e); end
    total++;
    cyc();
    dmem_ack = 1'b1;
    run = 1'b0;
    #1;
    e = '0; e.dmem_req = 1'b1; e.dmem_we = 1'b1; e.pc_advance = 1'b1;
    if (obs !== e) begin bad++; $display("FAIL st_ack: got %h want %h", obs, e); end
    total++;
    cyc();
    dmem_ack = 1'b0;
    cyc();
    #1;
    e = '0;
    if (obs !== e) begin bad++; $display("FAIL run_drop_idle: got %h want %h", obs, e); end
    total++;
  endtask

  task automatic test_fetch_timeout();
    outs_t e;
    do_reset();
    run = 1'b1;
    cyc();
    for (int k = 0; k < 16; k++) begin
      #1;
      e = '0; e.imem_req = 1'b1;
      if (obs !== e) begin bad++; $display("FAIL timeout_wait[%0d]: got %h want %h", k, obs, e); end
      total++;
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      imem_ack = 1'b1; imem_rdata = 8'h82;
      #1;
      e = '0; e.fault = 1'b1; e.fault_code = 2'd3;
      if (obs !== e) begin bad++; $display("FAIL timeout_fault[%0d]: got %h want %h", k, obs, e); end
      total++;
      cyc();
    end
    do_reset();
    #1;
    e = '0;
    if (obs !== e) begin bad++; $display("FAIL timeout_cleared: got %h want %h", obs, e); end
    total++;
  endtask

  task automatic test_decode_faults();
    outs_t e;
    do_reset();
    run = 1'b1;
    cyc();
    imem_ack = 1'b1; imem_rdata = 8'hB0;
    cyc();
    imem_ack = 1'b0;
    #1;
    e = '0;
    if (obs !== e) begin bad++; $display("FAIL illegal_decode: got %h want %h", obs, e); end
    total++;
    cyc();
    for (int k = 0; k < 2; k++) begin
      #1;
      e = '0; e.fault = 1'b1; e.fault_code = 2'd1;
      if (obs !== e) begin bad++; $display("FAIL illegal_fault[%0d]: got %h want %h", k, obs, e); end
      total++;
      cyc();
    end
    do_reset();
    run = 1'b1;
    cyc();
    imem_ack = 1'b1; imem_rdata = 8'h1C;
    cyc();
    imem_ack = 1'b0;
    #1;
    e = '0; e.reg_addr = 4'hC;
    if (obs !== e) begin bad++; $display("FAIL badreg_decode: got %h want %h", obs, e); end
    total++;
    cyc();
    #1;
    e = '0; e.fault = 1'b1; e.fault_code = 2'd2;
    if (obs !== e) begin bad++; $display("FAIL badreg_fault: got %h want %h", obs, e); end
    total++;
  endtask

  task automatic test_halt_and_reset();
    outs_t e;
    do_reset();
    run = 1'b1;
    cyc();
    imem_ack = 1'b1; imem_rdata = 8'hF0;
    cyc();
    imem_ack = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      imem_ack = k[0];
      #1;
      e = '0; e.halted = 1'b1;
      if (obs !== e) begin bad++; $display("FAIL halt_hold[%0d]: got %h want %h", k, obs, e); end
      total++;
      cyc();
    end
    imem_ack = 1'b0;
    do_reset();
    run = 1'b1;
    cyc();
    imem_ack = 1'b1; imem_rdata = 8'h90;
    cyc();
    imem_ack = 1'b0;
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    dmem_ack = 1'b1;
    #1;
    e = '0;
    if (obs !== e) begin bad++; $display("FAIL reset_mid_ld: got %h want %h", obs, e); end
    total++;
    reset    = 1'b0;
    dmem_ack = 1'b0;
    cyc();
    #1;
    e = '0; e.imem_req = 1'b1;
    if (obs !== e) begin bad++; $display("FAIL resume_fetch: got %h want %h", obs, e); end
    total++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ldi_latency();
    test_program();
    test_mem();
    test_fetch_timeout();
    test_decode_faults();
    test_halt_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
